gbe_rx_udp: RTL and testbench

Receive-side counterpart of the GbE UDP transmit path, in the mac_clk domain. Consumes the MAC receive byte stream and parses the Ethernet/IPv4/UDP headers. Filters frames on local MAC, IP and port, then presents the UDP payload to the application with the source IP and port. Frames that fail a check are dropped and counted.

---
 rtl/gbe_pkg.sv | 33 +++
 rtl/gbe_ip_csum_chk.sv | 51 +++++
 rtl/gbe_rx_udp.sv | 274 +++++++++++++++++++++++++++
 tb/tb_gbe_rx_udp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_pkg.sv
// Shared constants, state encoding and checksum helper for the GbE UDP
// receive and transmit paths.
package gbe_pkg;

    localparam int MAC_HDR_SIZE = 14;
    localparam int IP_HDR_SIZE  = 20;
    localparam int UDP_HDR_SIZE = 8;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_MAC = 3'd1,
        ST_HDR_IP  = 3'd2,
        ST_HDR_UDP = 3'd3,
        ST_DATA    = 3'd4,
        ST_PAD     = 3'd5,
        ST_STATUS  = 3'd6,
        ST_DROP    = 3'd7
    } rx_state_t;

    // One's-complement add: 18-bit sum with the end-around carry folded twice.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [17:0] s;
        s = {2'b00, a} + {2'b00, b};
        s = {2'b00, s[15:0]} + {16'h0000, s[17:16]};
        s = {2'b00, s[15:0]} + {16'h0000, s[17:16]};
        return s[15:0];
    endfunction

endpackage

// File: rtl/gbe_ip_csum_chk.sv
// Streaming 16-bit one's-complement accumulator over a byte stream (high
// byte first); result_ok_o reflects the sum including the byte presented now.
module gbe_ip_csum_chk
    import gbe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic       result_ok_o
);

    logic [15:0] acc_q, acc_d;
    logic [7:0]  hi_q, hi_d;
    logic        phase_q, phase_d;

    always_comb begin
        acc_d   = acc_q;
        hi_d    = hi_q;
        phase_d = phase_q;
        if (clr_i) begin
            acc_d   = 16'h0000;
            hi_d    = 8'h00;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (!phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                acc_d   = csum_add(acc_q, {hi_q, data_i});
                phase_d = 1'b0;
            end
        end
    end

    assign result_ok_o = (acc_d == 16'hFFFF);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= 16'h0000;
            hi_q    <= 8'h00;
            phase_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/gbe_rx_udp.sv
// GbE receive path: parses Ethernet/IPv4/UDP headers, filters on local
// MAC/IP/port and streams the UDP payload to the application.
module gbe_rx_udp
    import gbe_pkg::*;
#(
    parameter bit CHECK_IP_CSUM = 1'b1,
    parameter bit ACCEPT_BCAST  = 1'b1
) (
    input  logic        mac_clk,
    input  logic        mac_rst_n,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    input  logic        local_enable,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic [7:0]  app_data,
    output logic        app_dvld,
    output logic        app_eof,
    output logic        app_done,
    output logic        app_ok,
    output logic [31:0] app_srcip,
    output logic [15:0] app_srcport,
    output logic [31:0] stat_rx_good,
    output logic [31:0] stat_rx_drop,
    output logic [2:0]  dbg_state_o
);

    localparam logic [5:0] MAC_LAST = 6'(MAC_HDR_SIZE - 1);
    localparam logic [5:0] IP_LAST  = 6'(MAC_HDR_SIZE + IP_HDR_SIZE - 1);
    localparam logic [5:0] UDP_LAST = 6'(MAC_HDR_SIZE + IP_HDR_SIZE + UDP_HDR_SIZE - 1);

    rx_state_t   state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic        mac_ok_q, mac_ok_d, bc_ok_q, bc_ok_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic        complete_q, complete_d, armed_q, armed_d;
    logic        pend_q, pend_d, pend_good_q, pend_good_d;
    logic [7:0]  app_data_q, app_data_d;
    logic        app_dvld_q, app_dvld_d, app_eof_q, app_eof_d;
    logic        app_done_q, app_done_d, app_ok_q, app_ok_d;
    logic [31:0] app_srcip_q, app_srcip_d;
    logic [15:0] app_srcport_q, app_srcport_d;
    logic [31:0] stat_good_q, stat_good_d, stat_drop_q, stat_drop_d;

    logic [7:0]  mac_byte, exp_byte;
    logic        exp_en, mac_ok_n, bc_ok_n, hdr_fail, csum_ok;
    logic        status_v, status_good, do_done, do_drop, trunc_eof;

    gbe_ip_csum_chk u_csum (
        .clk_i       (mac_clk),
        .rst_n_i     (mac_rst_n),
        .clr_i       (state_q == ST_IDLE),
        .en_i        (mac_rx_dvld && (state_q == ST_HDR_IP)),
        .data_i      (mac_rx_data),
        .result_ok_o (csum_ok)
    );

    always_comb begin
        mac_byte = 8'h00;
        exp_en   = 1'b0;
        exp_byte = 8'h00;
        case (idx_q)
            6'd1:  mac_byte = local_mac[39:32];
            6'd2:  mac_byte = local_mac[31:24];
            6'd3:  mac_byte = local_mac[23:16];
            6'd4:  mac_byte = local_mac[15:8];
            6'd5:  mac_byte = local_mac[7:0];
            6'd12: begin exp_en = 1'b1; exp_byte = ETHERTYPE_IPV4[15:8]; end
            6'd13: begin exp_en = 1'b1; exp_byte = ETHERTYPE_IPV4[7:0];  end
            6'd14: begin exp_en = 1'b1; exp_byte = IP_VER_IHL;           end
            6'd23: begin exp_en = 1'b1; exp_byte = IP_PROTO_UDP;         end
            6'd30: begin exp_en = 1'b1; exp_byte = local_ip[31:24];      end
            6'd31: begin exp_en = 1'b1; exp_byte = local_ip[23:16];      end
            6'd32: begin exp_en = 1'b1; exp_byte = local_ip[15:8];       end
            6'd33: begin exp_en = 1'b1; exp_byte = local_ip[7:0];        end
            6'd36: begin exp_en = 1'b1; exp_byte = local_port[15:8];     end
            6'd37: begin exp_en = 1'b1; exp_byte = local_port[7:0];      end
            default: ;
        endcase
    end

    assign mac_ok_n = mac_ok_q && (mac_rx_data == mac_byte);
    assign bc_ok_n  = bc_ok_q && (mac_rx_data == 8'hFF);

    always_comb begin
        hdr_fail = exp_en && (mac_rx_data != exp_byte);
        if (idx_q == 6'd5 && !(mac_ok_n || (ACCEPT_BCAST && bc_ok_n)))
            hdr_fail = 1'b1;
        if (idx_q == IP_LAST && CHECK_IP_CSUM && !csum_ok)
            hdr_fail = 1'b1;
        if (idx_q == 6'd39 && ({len_hi_q, mac_rx_data} <= 16'(UDP_HDR_SIZE)))
            hdr_fail = 1'b1;
    end

    // A status pulse seen while dvld is still high is parked until dvld falls.
    assign status_v    = mac_rx_goodframe || mac_rx_badframe || pend_q;
    assign status_good = pend_q ? pend_good_q : mac_rx_goodframe;
    // Truncation with a byte already on the output: flag it as the last one now.
    assign trunc_eof   = (state_q == ST_DATA) && !mac_rx_dvld && app_dvld_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        len_hi_d      = len_hi_q;
        mac_ok_d      = mac_ok_q;
        bc_ok_d       = bc_ok_q;
        src_ip_d      = src_ip_q;
        src_port_d    = src_port_q;
        complete_d    = complete_q;
        armed_d       = armed_q || !mac_rx_dvld;
        pend_d        = pend_q;
        pend_good_d   = pend_good_q;
        app_data_d    = app_data_q;
        app_dvld_d    = 1'b0;
        app_eof_d     = 1'b0;
        app_done_d    = 1'b0;
        app_ok_d      = 1'b0;
        app_srcip_d   = app_srcip_q;
        app_srcport_d = app_srcport_q;
        stat_good_d   = stat_good_q;
        stat_drop_d   = stat_drop_q;
        do_done       = 1'b0;
        do_drop       = 1'b0;

        if (state_q != ST_IDLE && mac_rx_dvld && (mac_rx_goodframe || mac_rx_badframe)) begin
            pend_d      = 1'b1;
            pend_good_d = mac_rx_goodframe;
        end

        case (state_q)
            ST_IDLE: begin
                if (mac_rx_dvld && armed_q) begin
                    idx_d      = 6'd1;
                    mac_ok_d   = (mac_rx_data == local_mac[47:40]);
                    bc_ok_d    = (mac_rx_data == 8'hFF);
                    complete_d = 1'b0;
                    state_d    = local_enable ? ST_HDR_MAC : ST_DROP;
                end
            end
            ST_HDR_MAC, ST_HDR_IP, ST_HDR_UDP: begin
                if (!mac_rx_dvld) begin
                    state_d = ST_DROP;
                end else begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q < 6'd6) begin
                        mac_ok_d = mac_ok_n;
                        bc_ok_d  = bc_ok_n;
                    end
                    if (idx_q >= 6'd26 && idx_q <= 6'd29) src_ip_d = {src_ip_q[23:0], mac_rx_data};
                    if (idx_q == 6'd34 || idx_q == 6'd35) src_port_d = {src_port_q[7:0], mac_rx_data};
                    if (idx_q == 6'd38) len_hi_d = mac_rx_data;
                    if (idx_q == 6'd39) rem_d = {len_hi_q, mac_rx_data} - 16'(UDP_HDR_SIZE);
                    if (hdr_fail) begin
                        state_d = ST_DROP;
                    end else if (idx_q == MAC_LAST) begin
                        state_d = ST_HDR_IP;
                    end else if (idx_q == IP_LAST) begin
                        state_d = ST_HDR_UDP;
                    end else if (idx_q == UDP_LAST) begin
                        state_d       = ST_DATA;
                        app_srcip_d   = src_ip_q;
                        app_srcport_d = src_port_q;
                    end
                end
            end
            ST_DATA: begin
                if (mac_rx_dvld) begin
                    app_data_d = mac_rx_data;
                    app_dvld_d = 1'b1;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        app_eof_d  = 1'b1;
                        complete_d = 1'b1;
                        state_d    = ST_PAD;
                    end
                end else begin
                    if (!app_dvld_q) app_eof_d = 1'b1;
                    if (status_v) do_done = 1'b1;
                    else state_d = ST_STATUS;
                end
            end
            ST_PAD, ST_STATUS: begin
                if (!mac_rx_dvld) begin
                    if (status_v) do_done = 1'b1;
                    else state_d = ST_STATUS;
                end
            end
            ST_DROP: begin
                if (!mac_rx_dvld && status_v) do_drop = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_done) begin
            app_done_d = 1'b1;
            app_ok_d   = status_good && complete_q;
            if (status_good && complete_q) stat_good_d = stat_good_q + 32'd1;
            else stat_drop_d = stat_drop_q + 32'd1;
        end
        if (do_drop) stat_drop_d = stat_drop_q + 32'd1;
        if (do_done || do_drop) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 6'd0;
            rem_q         <= 16'h0000;
            len_hi_q      <= 8'h00;
            mac_ok_q      <= 1'b0;
            bc_ok_q       <= 1'b0;
            src_ip_q      <= 32'h0;
            src_port_q    <= 16'h0;
            complete_q    <= 1'b0;
            armed_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_good_q   <= 1'b0;
            app_data_q    <= 8'h00;
            app_dvld_q    <= 1'b0;
            app_eof_q     <= 1'b0;
            app_done_q    <= 1'b0;
            app_ok_q      <= 1'b0;
            app_srcip_q   <= 32'h0;
            app_srcport_q <= 16'h0;
            stat_good_q   <= 32'h0;
            stat_drop_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            len_hi_q      <= len_hi_d;
            mac_ok_q      <= mac_ok_d;
            bc_ok_q       <= bc_ok_d;
            src_ip_q      <= src_ip_d;
            src_port_q    <= src_port_d;
            complete_q    <= complete_d;
            armed_q       <= armed_d;
            pend_q        <= pend_d;
            pend_good_q   <= pend_good_d;
            app_data_q    <= app_data_d;
            app_dvld_q    <= app_dvld_d;
            app_eof_q     <= app_eof_d;
            app_done_q    <= app_done_d;
            app_ok_q      <= app_ok_d;
            app_srcip_q   <= app_srcip_d;
            app_srcport_q <= app_srcport_d;
            stat_good_q   <= stat_good_d;
            stat_drop_q   <= stat_drop_d;
        end
    end

    // app_dvld qualifies app_data and app_eof; the stream has no backpressure.
    assign app_data     = app_data_q;
    assign app_dvld     = app_dvld_q;
    assign app_eof      = app_eof_q || trunc_eof;
    assign app_done     = app_done_q;
    assign app_ok       = app_ok_q;
    assign app_srcip    = app_srcip_q;
    assign app_srcport  = app_srcport_q;
    assign stat_rx_good = stat_good_q;
    assign stat_rx_drop = stat_drop_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gbe_rx_udp.sv
// Directed bench for gbe_rx_udp: delivery, filtering, padding, bad status,
// truncation with back-to-back frames, and reset in mid-frame.
module tb_gbe_rx_udp;

    localparam logic [47:0] LMAC  = 48'h0200_0000_0002;
    localparam logic [31:0] LIP   = 32'h0A00_0002;
    localparam logic [15:0] LPORT = 16'd7148;
    localparam logic [15:0] CS18  = 16'h26C5;  // header checksum, UDP length 18
    localparam logic [15:0] CS9   = 16'h26CE;  // header checksum, UDP length 9

    logic        mac_clk = 1'b0;
    logic        mac_rst_n = 1'b0;
    logic [7:0]  mac_rx_data = 8'h00;
    logic        mac_rx_dvld = 1'b0;
    logic        mac_rx_goodframe = 1'b0;
    logic        mac_rx_badframe = 1'b0;
    logic        local_enable = 1'b1;
    logic [47:0] local_mac = LMAC;
    logic [31:0] local_ip = LIP;
    logic [15:0] local_port = LPORT;
    logic [7:0]  app_data;
    logic        app_dvld, app_eof, app_done, app_ok;
    logic [31:0] app_srcip;
    logic [15:0] app_srcport;
    logic [31:0] stat_rx_good, stat_rx_drop;
    logic [2:0]  dbg_state;

    gbe_rx_udp dut (
        .mac_clk(mac_clk), .mac_rst_n(mac_rst_n), .mac_rx_data(mac_rx_data),
        .mac_rx_dvld(mac_rx_dvld), .mac_rx_goodframe(mac_rx_goodframe),
        .mac_rx_badframe(mac_rx_badframe), .local_enable(local_enable),
        .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
        .app_data(app_data), .app_dvld(app_dvld), .app_eof(app_eof),
        .app_done(app_done), .app_ok(app_ok), .app_srcip(app_srcip),
        .app_srcport(app_srcport), .stat_rx_good(stat_rx_good),
        .stat_rx_drop(stat_rx_drop), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #4 mac_clk = ~mac_clk;

    int checks = 0;
    int fails = 0;
    logic [7:0]  frm [0:63];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic        rx_eof_q[$];
    logic        ok_q[$];
    int          done_cnt = 0;
    int          eof_only_cnt = 0;
    logic [31:0] done_srcip = 32'h0;
    logic [15:0] done_srcport = 16'h0;
    logic [31:0] exp_good = 32'd0;
    logic [31:0] exp_drop = 32'd0;

    // scoreboard capture, sampled on the falling edge
    always @(negedge mac_clk) begin
        if (mac_rst_n) begin
            if (app_dvld) begin
                rx_q.push_back(app_data);
                rx_eof_q.push_back(app_eof);
            end else if (app_eof) begin
                eof_only_cnt++;
            end
            if (app_done) begin
                done_cnt++;
                ok_q.push_back(app_ok);
                done_srcip   = app_srcip;
                done_srcport = app_srcport;
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        rx_eof_q.delete();
        ok_q.delete();
        done_cnt = 0;
        eof_only_cnt = 0;
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] dport,
                               input logic [15:0] udp_len, input logic [15:0] csum);
        logic [15:0] tl;
        tl = udp_len + 16'd20;
        for (int i = 0; i < 64; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) frm[i] = dmac[47 - 8*i -: 8];
        frm[6] = 8'h02; frm[11] = 8'h01;
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
        frm[16] = tl[15:8]; frm[17] = tl[7:0];
        frm[20] = 8'h40; frm[22] = 8'h40; frm[23] = 8'h11;
        frm[24] = csum[15:8]; frm[25] = csum[7:0];
        frm[26] = 8'h0A; frm[29] = 8'h01;
        frm[30] = 8'h0A; frm[33] = 8'h02;
        frm[34] = 8'h13; frm[35] = 8'h88;
        frm[36] = dport[15:8]; frm[37] = dport[7:0];
        frm[38] = udp_len[15:8]; frm[39] = udp_len[7:0];
        exp_q.delete();
        for (int i = 0; i < int'(udp_len) - 8; i++) begin
            frm[42 + i] = 8'hA0 + 8'(i);
            exp_q.push_back(8'hA0 + 8'(i));
        end
    endtask

    // driver: bytes, then the status pulse in the cycle dvld falls
    task automatic send_frame(input int nbytes, input logic good);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge mac_clk); #1;
            mac_rx_dvld = 1'b1; mac_rx_data = frm[i];
            mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0;
        end
        @(posedge mac_clk); #1;
        mac_rx_dvld = 1'b0; mac_rx_data = 8'h00;
        mac_rx_goodframe = good; mac_rx_badframe = !good;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mac_clk); #1;
            mac_rx_dvld = 1'b0; mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge mac_clk);
        #1;
        checks++; if ({app_dvld, app_eof, app_done, app_ok} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {app_dvld, app_eof, app_done, app_ok}); end
        checks++; if ({app_data, app_srcip, app_srcport} !== 56'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", {app_data, app_srcip, app_srcport}); end
        checks++; if ({stat_rx_good, stat_rx_drop} !== 64'h0) begin fails++; $display("FAIL reset_stats: got %h expected 0", {stat_rx_good, stat_rx_drop}); end
        checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        mac_rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_valid();
        int eof_n, eof_at;
        clear_mon();
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(4);
        exp_good++;
        checks++; if (rx_q.size() != 10) begin fails++; $display("FAIL valid_count: got %0d expected 10", rx_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL valid_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        eof_n = 0; eof_at = -1;
        for (int i = 0; i < rx_eof_q.size(); i++) if (rx_eof_q[i]) begin eof_n++; eof_at = i; end
        checks++; if (eof_n != 1 || eof_at != 9) begin fails++; $display("FAIL valid_eof: got n=%0d at=%0d expected n=1 at=9", eof_n, eof_at); end
        checks++; if (done_cnt != 1 || ok_q.size() != 1 || ok_q[0] !== 1'b1) begin fails++; $display("FAIL valid_done: got cnt=%0d ok=%b expected cnt=1 ok=1", done_cnt, (ok_q.size() > 0) ? ok_q[0] : 1'bx); end
        checks++; if (done_srcip !== 32'h0A000001) begin fails++; $display("FAIL valid_srcip: got %h expected 0a000001", done_srcip); end
        checks++; if (done_srcport !== 16'd5000) begin fails++; $display("FAIL valid_srcport: got %0d expected 5000", done_srcport); end
        checks++; if (stat_rx_good !== exp_good || stat_rx_drop !== exp_drop) begin fails++; $display("FAIL valid_stats: got %0d/%0d expected %0d/%0d", stat_rx_good, stat_rx_drop, exp_good, exp_drop); end
    endtask

    task automatic test_filter();
        clear_mon();
        build_frame(LMAC, LPORT + 16'd1, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(3);
        build_frame(LMAC, LPORT, 16'd18, CS18);
        frm[24] = frm[24] ^ 8'h01;
        send_frame(60, 1'b1);
        idle(3);
        exp_drop += 2;
        checks++; if (rx_q.size() != 0 || eof_only_cnt != 0) begin fails++; $display("FAIL filter_nodata: got %0d bytes %0d eof expected 0", rx_q.size(), eof_only_cnt); end
        checks++; if (done_cnt != 0) begin fails++; $display("FAIL filter_nodone: got %0d expected 0", done_cnt); end
        checks++; if (stat_rx_drop !== 32'd2 || stat_rx_good !== exp_good) begin fails++; $display("FAIL filter_stats: got %0d/%0d expected %0d/2", stat_rx_good, stat_rx_drop, exp_good); end
    endtask

    task automatic test_mac_and_enable();
        clear_mon();
        build_frame(48'hFFFF_FFFF_FFFF, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(3);
        exp_good++;
        checks++; if (rx_q.size() != 10 || done_cnt != 1) begin fails++; $display("FAIL bcast_accept: got %0d bytes %0d done expected 10/1", rx_q.size(), done_cnt); end
        clear_mon();
        build_frame(48'h0200_0000_0003, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(3);
        local_enable = 1'b0;
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(3);
        local_enable = 1'b1;
        exp_drop += 2;
        checks++; if (rx_q.size() != 0 || done_cnt != 0) begin fails++; $display("FAIL mac_disable_drop: got %0d bytes %0d done expected 0/0", rx_q.size(), done_cnt); end
        checks++; if (stat_rx_good !== exp_good || stat_rx_drop !== exp_drop) begin fails++; $display("FAIL mac_stats: got %0d/%0d expected %0d/%0d", stat_rx_good, stat_rx_drop, exp_good, exp_drop); end
    endtask

    task automatic test_pad();
        clear_mon();
        build_frame(LMAC, LPORT, 16'd9, CS9);
        send_frame(60, 1'b1);
        idle(4);
        exp_good++;
        checks++; if (rx_q.size() != 1) begin fails++; $display("FAIL pad_count: got %0d expected 1", rx_q.size()); end
        checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA0 || rx_eof_q[0] !== 1'b1) begin fails++; $display("FAIL pad_byte: got %h eof %b expected a0 eof 1", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_eof_q.size() > 0) ? rx_eof_q[0] : 1'bx); end
        checks++; if (done_cnt != 1 || ok_q.size() != 1 || ok_q[0] !== 1'b1) begin fails++; $display("FAIL pad_done: got cnt=%0d expected cnt=1 ok=1", done_cnt); end
        checks++; if (stat_rx_good !== exp_good) begin fails++; $display("FAIL pad_stats: got %0d expected %0d", stat_rx_good, exp_good); end
    endtask

    task automatic test_badframe();
        clear_mon();
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(60, 1'b0);
        idle(4);
        exp_drop++;
        checks++; if (rx_q.size() != 10 || rx_eof_q.size() != 10 || rx_eof_q[9] !== 1'b1) begin fails++; $display("FAIL bad_payload: got %0d bytes expected 10 with eof", rx_q.size()); end
        checks++; if (done_cnt != 1 || ok_q.size() != 1 || ok_q[0] !== 1'b0) begin fails++; $display("FAIL bad_done: got cnt=%0d expected cnt=1 ok=0", done_cnt); end
        checks++; if (stat_rx_good !== exp_good || stat_rx_drop !== exp_drop) begin fails++; $display("FAIL bad_stats: got %0d/%0d expected %0d/%0d", stat_rx_good, stat_rx_drop, exp_good, exp_drop); end
    endtask

    task automatic test_back_to_back();
        int eof_n;
        clear_mon();
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(46, 1'b1);
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(4);
        exp_drop++;
        exp_good++;
        checks++; if (rx_q.size() != 14) begin fails++; $display("FAIL b2b_count: got %0d expected 14", rx_q.size()); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== 8'hA0 + 8'((i < 4) ? i : i - 4)) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'hA0 + 8'((i < 4) ? i : i - 4)); end
        end
        eof_n = 0;
        for (int i = 0; i < rx_eof_q.size(); i++) if (rx_eof_q[i]) eof_n++;
        checks++; if (eof_n != 2 || rx_eof_q.size() != 14 || rx_eof_q[3] !== 1'b1 || rx_eof_q[13] !== 1'b1) begin fails++; $display("FAIL b2b_eof: got %0d eofs expected 2 at 3 and 13", eof_n); end
        checks++; if (eof_only_cnt != 0) begin fails++; $display("FAIL b2b_eof_only: got %0d expected 0", eof_only_cnt); end
        checks++; if (done_cnt != 2 || ok_q.size() != 2 || ok_q[0] !== 1'b0 || ok_q[1] !== 1'b1) begin fails++; $display("FAIL b2b_done: got cnt=%0d expected 2 with ok 0 then 1", done_cnt); end
        checks++; if (stat_rx_good !== exp_good || stat_rx_drop !== exp_drop) begin fails++; $display("FAIL b2b_stats: got %0d/%0d expected %0d/%0d", stat_rx_good, stat_rx_drop, exp_good, exp_drop); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build_frame(LMAC, LPORT, 16'd18, CS18);
        for (int i = 0; i < 46; i++) begin
            @(posedge mac_clk); #1;
            mac_rx_dvld = 1'b1; mac_rx_data = frm[i];
        end
        @(posedge mac_clk); #1;
        mac_rx_data = frm[46];
        mac_rst_n = 1'b0;
        #1;
        checks++; if ({app_dvld, app_eof, app_done, app_ok, app_data} !== 12'h000) begin fails++; $display("FAIL rstmid_outputs: got %h expected 0", {app_dvld, app_eof, app_done, app_ok, app_data}); end
        checks++; if ({stat_rx_good, stat_rx_drop} !== 64'h0 || dbg_state !== 3'd0) begin fails++; $display("FAIL rstmid_stats: got %h state %0d expected 0", {stat_rx_good, stat_rx_drop}, dbg_state); end
        clear_mon();
        @(posedge mac_clk); #1;
        mac_rst_n = 1'b1;
        mac_rx_data = frm[47];
        for (int i = 48; i < 60; i++) begin
            @(posedge mac_clk); #1;
            mac_rx_data = frm[i];
        end
        @(posedge mac_clk); #1;
        mac_rx_dvld = 1'b0; mac_rx_goodframe = 1'b1;
        idle(4);
        exp_good = 32'd0;
        exp_drop = 32'd0;
        checks++; if (rx_q.size() != 0 || done_cnt != 0 || eof_only_cnt != 0) begin fails++; $display("FAIL rstmid_ignored: got %0d bytes %0d done expected 0/0", rx_q.size(), done_cnt); end
        checks++; if (stat_rx_good !== 32'd0 || stat_rx_drop !== 32'd0) begin fails++; $display("FAIL rstmid_nocount: got %0d/%0d expected 0/0", stat_rx_good, stat_rx_drop); end
        build_frame(LMAC, LPORT, 16'd18, CS18);
        send_frame(60, 1'b1);
        idle(4);
        exp_good++;
        checks++; if (rx_q.size() != 10 || done_cnt != 1 || ok_q.size() != 1 || ok_q[0] !== 1'b1) begin fails++; $display("FAIL rstmid_after: got %0d bytes %0d done expected 10/1 ok", rx_q.size(), done_cnt); end
        checks++; if (stat_rx_good !== exp_good || stat_rx_drop !== exp_drop) begin fails++; $display("FAIL rstmid_after_stats: got %0d/%0d expected %0d/%0d", stat_rx_good, stat_rx_drop, exp_good, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_filter();
        test_mac_and_enable();
        test_pad();
        test_badframe();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
